lms_sat_round_pipe: RTL and testbench
=====================================

Name: lms_sat_round_pipe

Overview:
- Pipelined, parametrised fixed-point narrowing stage for the LMS datapath.
- Takes a wide signed accumulator result, applies a programmable right shift with selectable rounding, then clamps to a signed OUT_W output.
- Valid/ready handshake, per-sample saturation flag, sticky overflow and saturating event counters for filter tuning.
- Sits between the FIR/LMS MAC accumulator and the 16-bit output/error path.

Parameters:
IN_W, 32, input width; signed two's complement.
OUT_W, 16, output width; signed; must be < IN_W.
SHIFT, 0, arithmetic right shift applied before clamping, 0..IN_W-OUT_W.
CNT_W, 16, width of the saturation event counters.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  global advance enable; low freezes the pipeline.
round_mode  in  1  0 = truncate (floor); 1 = round half up (add 2^(SHIFT-1) before the shift).
in_valid  in  1  input sample valid.
in_ready  out  1  stage can accept a sample.
in_data  in  IN_W  signed input sample.
out_valid  out  1  output sample valid.
out_ready  in  1  downstream accepts the sample.
out_data  out  OUT_W  signed saturated result.
out_sat  out  2  per-sample flag aligned with out_data: [1] clamped high, [0] clamped low.
clr_stats  in  1  synchronous clear of the counters and the sticky flag.
sat_hi_cnt  out  CNT_W  count of accepted samples clamped high.
sat_lo_cnt  out  CNT_W  count of accepted samples clamped low.
sat_sticky  out  1  set on any clamp; held until clr_stats or rst.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_sat=0, sat_hi_cnt=0, sat_lo_cnt=0, sat_sticky=0, all internal valids=0.
  - rst overrides every other input, including mid-stream; in-flight samples are dropped.
- Advance condition: adv = en && (!out_valid || out_ready). in_ready = adv. A transfer occurs when in_valid && in_ready.
- Pipeline, 2 stages, moving only when adv=1:
  - S1 registers the shifted/rounded value in IN_W+1 bits:
    - r = in_data sign-extended to IN_W+1.
    - If round_mode=1 and SHIFT>0, add 2^(SHIFT-1).
    - Then arithmetic shift right by SHIFT.
    - The extra bit guarantees that rounding never wraps; e.g. 0x7FFFFFFF rounds upward without becoming negative.
  - S2 clamps the S1 value:
    - If > 2^(OUT_W-1)-1: out_data = max positive, out_sat = 2'b10.
    - Else if < -2^(OUT_W-1): out_data = min negative, out_sat = 2'b01.
    - Else: out_data = low OUT_W bits, out_sat = 2'b00.
  - All comparisons are signed. An unsigned compare is a defect.
- Latency: exactly 2 adv cycles from input transfer to out_valid. Throughput is 1 sample/cycle when out_ready=1 and en=1.
- Backpressure:
  - out_valid && !out_ready holds out_data, out_sat and S1 unchanged, and in_ready=0.
  - No sample is lost or duplicated.
  - Bubbles (in_valid=0) propagate as valid=0.
- en=0: in_ready=0; every register holds. out_valid stays asserted if it was already set, but no new transfer occurs until en returns high.
- Statistics:
  - Counters and sticky flag update only when an output transfer occurs (out_valid && out_ready) with a nonzero out_sat.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - If clr_stats and an event occur in the same cycle, the clear wins: the result is 0 and the event is discarded.
  - clr_stats does not affect the data pipeline.
- round_mode is sampled when S1 loads; changing it mid-stream affects only later samples.

Decomposition:
- Shared package lms_fixed_pkg:
  - Constants ROUND_TRUNC=1'b0 and ROUND_HALF_UP=1'b1.
  - SAT_NONE/SAT_HI/SAT_LO encodings for out_sat.
  - Function sat_limits(OUT_W), returning the max/min signed constants.
- One sub-module, lms_sat_counter:
  - A CNT_W saturating counter with inc and clr inputs, clr priority.
  - Instantiated twice, for hi and lo.

Test Plan:
- IN_W=32, OUT_W=16, SHIFT=0; inputs 40000, -40000, 1234 back-to-back with out_ready=1 -> outputs 32767/10, -32768/01, 1234/00 on cycles 2, 3, 4 after the first transfer; sat_hi_cnt=1, sat_lo_cnt=1, sat_sticky=1.
- SHIFT=4; inputs 24 and -24, once with round_mode=0 and once with round_mode=1 -> truncate gives 1 and -2; round half up gives 2 and -1; 0x7FFFFFFF with round_mode=1 -> 32767, flagged high, no wrap.
- Backpressure: stream 100, 200, 300 with out_ready low for 3 cycles after the first output -> in_ready=0 while stalled; outputs appear in order 100, 200, 300, each exactly once.
- CNT_W=4; 20 consecutive 50000 samples -> sat_hi_cnt stops at 15; assert clr_stats in the same cycle as a clamp event -> counter reads 0 and sat_sticky=0 on the next cycle.
- en toggled low for 2 cycles mid-stream -> outputs frozen and in_ready=0; the sequence resumes intact afterwards.
- rst pulsed while 2 samples are in flight -> next cycle out_valid=0 and all counters are 0; a new sample appears 2 cycles after its transfer.

Source files
------------

// File: rtl/lms_fixed_pkg.sv
// Shared fixed-point constants and helpers for the LMS narrowing datapath.
package lms_fixed_pkg;

    localparam logic ROUND_TRUNC   = 1'b0;
    localparam logic ROUND_HALF_UP = 1'b1;

    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_LO   = 2'b01,
        SAT_HI   = 2'b10
    } sat_e;

    typedef struct packed {
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
    } sat_lim_t;

    // Output widths up to 63 bits are representable in the 64-bit limit fields.
    function automatic sat_lim_t sat_limits(input int out_w);
        sat_lim_t lim;
        lim.max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lim.min_v = -(64'sd1 <<< (out_w - 1));
        return lim;
    endfunction

endpackage

// File: rtl/lms_sat_counter.sv
// Saturating event counter; clear has priority over increment.
module lms_sat_counter
    import lms_fixed_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/lms_sat_round_pipe.sv
// Two-stage narrowing stage: shift/round into IN_W+1 bits, then signed clamp to OUT_W,
// with valid/ready flow control and saturation statistics.
module lms_sat_round_pipe
    import lms_fixed_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             round_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_sat,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] sat_hi_cnt,
    output logic [CNT_W-1:0] sat_lo_cnt,
    output logic             sat_sticky
);

    localparam int                  RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [IN_W:0]       RND_INC = (SHIFT > 0) ? ((IN_W + 1)'(1) << RND_POS) : '0;
    localparam sat_lim_t            LIM     = sat_limits(OUT_W);
    localparam logic signed [IN_W:0] MAX_V  = (IN_W + 1)'(LIM.max_v);
    localparam logic signed [IN_W:0] MIN_V  = (IN_W + 1)'(LIM.min_v);

    logic                    adv;
    logic [IN_W:0]           rnd_sum;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [IN_W:0]    s1_data_q, s1_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    sat_e                    out_sat_q, out_sat_d;
    logic                    sticky_q, sticky_d;
    logic                    out_xfer;
    logic                    hi_evt;
    logic                    lo_evt;

    assign adv      = en && (!out_valid_q || out_ready);
    assign in_ready = adv;

    // The extra top bit keeps the rounding increment from wrapping at full scale.
    always_comb begin
        rnd_sum = {in_data[IN_W-1], in_data};
        if (round_mode == ROUND_HALF_UP) begin
            rnd_sum = rnd_sum + RND_INC;
        end
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = $signed(rnd_sum) >>> SHIFT;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_data_q > MAX_V) begin
                    out_data_d = MAX_V[OUT_W-1:0];
                    out_sat_d  = SAT_HI;
                end else if (s1_data_q < MIN_V) begin
                    out_data_d = MIN_V[OUT_W-1:0];
                    out_sat_d  = SAT_LO;
                end else begin
                    out_data_d = s1_data_q[OUT_W-1:0];
                    out_sat_d  = SAT_NONE;
                end
            end
        end
    end

    assign out_xfer = out_valid_q && adv;
    assign hi_evt   = out_xfer && (out_sat_q == SAT_HI);
    assign lo_evt   = out_xfer && (out_sat_q == SAT_LO);

    always_comb begin
        sticky_d = sticky_q;
        if (clr_stats) begin
            sticky_d = 1'b0;
        end else if (hi_evt || lo_evt) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= SAT_NONE;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sticky_q    <= sticky_d;
        end
    end

    lms_sat_counter #(.CNT_W(CNT_W)) u_hi_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hi_evt),
        .clr (clr_stats),
        .cnt (sat_hi_cnt)
    );

    lms_sat_counter #(.CNT_W(CNT_W)) u_lo_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lo_evt),
        .clr (clr_stats),
        .cnt (sat_lo_cnt)
    );

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_lms_sat_round_pipe.sv
// Scoreboard bench: two instances (SHIFT=0/CNT_W=4 and SHIFT=4/CNT_W=16) share one stimulus stream.
module tb_lms_sat_round_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, round_mode, in_valid, out_ready, clr_stats;
    logic [31:0] in_data;

    logic        in_ready_a, out_valid_a, sticky_a;
    logic [15:0] out_data_a;
    logic [1:0]  out_sat_a;
    logic [3:0]  hi_a, lo_a;

    logic        in_ready_b, out_valid_b, sticky_b;
    logic [15:0] out_data_b;
    logic [1:0]  out_sat_b;
    logic [15:0] hi_b, lo_b;

    lms_sat_round_pipe #(.IN_W(32), .OUT_W(16), .SHIFT(0), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .round_mode(round_mode),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a),
        .clr_stats(clr_stats), .sat_hi_cnt(hi_a), .sat_lo_cnt(lo_a), .sat_sticky(sticky_a)
    );

    lms_sat_round_pipe #(.IN_W(32), .OUT_W(16), .SHIFT(4), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .round_mode(round_mode),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b),
        .clr_stats(clr_stats), .sat_hi_cnt(hi_b), .sat_lo_cnt(lo_b), .sat_sticky(sticky_b)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  sat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ex(input int v, input logic [1:0] s);
        exp_t r;
        r.data = v[15:0];
        r.sat  = s;
        return r;
    endfunction

    // Drive one sample and hold it until accepted; expectations are queued at acceptance.
    task automatic sv(input int d, input logic rm, input int ea, input logic [1:0] sa,
                      input int eb, input logic [1:0] sb);
        int w = 0;
        in_valid   = 1'b1;
        in_data    = d;
        round_mode = rm;
        #1;
        while (!in_ready_a && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (in_ready_a) begin
            q_a.push_back(ex(ea, sa));
            q_b.push_back(ex(eb, sb));
        end
        check("in_ready_accept", in_ready_a, 1);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("drain_left", q_a.size() + q_b.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: pops on each output handshake and tracks expected statistics.
    initial begin
        exp_t ea, eb;
        logic hs_a, hs_b;
        int   m_hi_a, m_lo_a, m_hi_b, m_lo_b;
        logic m_st_a, m_st_b;
        m_hi_a = 0; m_lo_a = 0; m_hi_b = 0; m_lo_b = 0; m_st_a = 0; m_st_b = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                q_a.delete();
                q_b.delete();
                m_hi_a = 0; m_lo_a = 0; m_hi_b = 0; m_lo_b = 0; m_st_a = 0; m_st_b = 0;
            end else begin
                check("a_hi_cnt", hi_a, m_hi_a);
                check("a_lo_cnt", lo_a, m_lo_a);
                check("a_sticky", sticky_a, m_st_a);
                check("b_hi_cnt", hi_b, m_hi_b);
                check("b_lo_cnt", lo_b, m_lo_b);
                check("b_sticky", sticky_b, m_st_b);
                ea = '0;
                eb = '0;
                hs_a = out_valid_a && out_ready && en;
                hs_b = out_valid_b && out_ready && en;
                if (hs_a) begin
                    check("a_output_expected", q_a.size() > 0, 1);
                    if (q_a.size() > 0) begin
                        ea = q_a.pop_front();
                        check("a_out_data", out_data_a, ea.data);
                        check("a_out_sat", out_sat_a, ea.sat);
                    end
                end
                if (hs_b) begin
                    check("b_output_expected", q_b.size() > 0, 1);
                    if (q_b.size() > 0) begin
                        eb = q_b.pop_front();
                        check("b_out_data", out_data_b, eb.data);
                        check("b_out_sat", out_sat_b, eb.sat);
                    end
                end
                if (clr_stats) begin
                    m_hi_a = 0; m_lo_a = 0; m_hi_b = 0; m_lo_b = 0; m_st_a = 0; m_st_b = 0;
                end else begin
                    if (hs_a && ea.sat == 2'b10) begin if (m_hi_a < 15) m_hi_a++; m_st_a = 1; end
                    if (hs_a && ea.sat == 2'b01) begin if (m_lo_a < 15) m_lo_a++; m_st_a = 1; end
                    if (hs_b && eb.sat == 2'b10) begin if (m_hi_b < 65535) m_hi_b++; m_st_b = 1; end
                    if (hs_b && eb.sat == 2'b01) begin if (m_lo_b < 65535) m_lo_b++; m_st_b = 1; end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; en = 1; round_mode = 0; in_valid = 0; in_data = 0; out_ready = 1; clr_stats = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_out_sat", out_sat_a, 0);
        check("rst_hi_cnt", hi_a, 0);
        check("rst_lo_cnt", lo_a, 0);
        check("rst_sticky", sticky_a, 0);
        check("rst_out_valid_b", out_valid_b, 0);
        @(negedge clk);
        rst = 0;

        // back-to-back clamp high, clamp low, pass-through
        sv(40000, 0, 32767, 2'b10, 2500, 2'b00);
        #1 check("lat_s1_only", out_valid_a, 0);
        sv(-40000, 0, -32768, 2'b01, -2500, 2'b00);
        #1 check("lat_out_valid", out_valid_a, 1);
        check("lat_out_data", out_data_a, 16'h7fff);
        sv(1234, 0, 1234, 2'b00, 77, 2'b00);
        idle();
        drain();
        #1;
        check("t1_hi_cnt", hi_a, 1);
        check("t1_lo_cnt", lo_a, 1);
        check("t1_sticky", sticky_a, 1);
        check("t1_b_hi_cnt", hi_b, 0);
        check("t1_b_sticky", sticky_b, 0);
        @(negedge clk);

        // rounding modes and clamp boundaries
        sv(24, 0, 24, 2'b00, 1, 2'b00);
        sv(-24, 0, -24, 2'b00, -2, 2'b00);
        sv(24, 1, 24, 2'b00, 2, 2'b00);
        sv(-24, 1, -24, 2'b00, -1, 2'b00);
        sv(32'h7fffffff, 1, 32767, 2'b10, 32767, 2'b10);
        sv(32'h80000000, 0, -32768, 2'b01, -32768, 2'b01);
        sv(32767, 0, 32767, 2'b00, 2047, 2'b00);
        sv(32768, 0, 32767, 2'b10, 2048, 2'b00);
        sv(-32768, 0, -32768, 2'b00, -2048, 2'b00);
        sv(-32769, 0, -32768, 2'b01, -2049, 2'b00);
        sv(524287, 1, 32767, 2'b10, 32767, 2'b10);
        sv(524287, 0, 32767, 2'b10, 32767, 2'b00);
        sv(-524296, 0, -32768, 2'b01, -32768, 2'b01);
        sv(-524296, 1, -32768, 2'b01, -32768, 2'b00);
        idle();
        drain();

        // backpressure for three cycles after the first output
        fork
            begin
                sv(100, 0, 100, 2'b00, 6, 2'b00);
                sv(200, 0, 200, 2'b00, 12, 2'b00);
                sv(300, 0, 300, 2'b00, 18, 2'b00);
                idle();
            end
            begin
                int w = 0;
                #1;
                while (!out_valid_a && w < 20) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                check("bp_first_out", out_valid_a, 1);
                @(negedge clk);
                out_ready = 0;
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("bp_in_ready", in_ready_a, 0);
                    check("bp_hold_valid", out_valid_a, 1);
                    check("bp_hold_data", out_data_a, 200);
                    @(negedge clk);
                end
                out_ready = 1;
            end
        join
        drain();

        // counter saturation at 15 with a 4-bit counter
        clr_stats = 1;
        @(negedge clk);
        clr_stats = 0;
        for (int i = 0; i < 20; i++) sv(50000, 0, 32767, 2'b10, 3125, 2'b00);
        idle();
        drain();
        #1;
        check("sat_hi_cnt_15", hi_a, 15);
        check("sat_lo_cnt_0", lo_a, 0);
        check("sat_sticky_set", sticky_a, 1);
        check("sat_b_hi_cnt_0", hi_b, 0);

        // clear coincident with a clamp event
        out_ready = 0;
        sv(50000, 0, 32767, 2'b10, 3125, 2'b00);
        idle();
        begin
            int w = 0;
            while (!out_valid_a && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
        end
        check("race_out_valid", out_valid_a, 1);
        clr_stats = 1;
        out_ready = 1;
        @(negedge clk);
        clr_stats = 0;
        #1;
        check("race_hi_cnt", hi_a, 0);
        check("race_sticky", sticky_a, 0);
        check("race_b_sticky", sticky_b, 0);

        // enable low for two cycles mid-stream
        fork
            begin
                for (int k = 1; k <= 6; k++) sv(16 * k, 0, 16 * k, 2'b00, k, 2'b00);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                en = 0;
                #1;
                check("en_out_valid", out_valid_a, 1);
                check("en_in_ready_0", in_ready_a, 0);
                check("en_hold_data_0", out_data_a, 32);
                @(negedge clk);
                #1;
                check("en_in_ready_1", in_ready_a, 0);
                check("en_hold_data_1", out_data_a, 32);
                check("en_hold_valid", out_valid_a, 1);
                @(negedge clk);
                en = 1;
                #1;
                check("en_hold_data_2", out_data_a, 32);
            end
        join
        drain();

        // reset while two samples are in flight
        sv(40000, 0, 32767, 2'b10, 2500, 2'b00);
        idle();
        drain();
        #1 check("pre_rst_hi_cnt", hi_a, 1);
        sv(-40000, 0, -32768, 2'b01, -2500, 2'b00);
        sv(1234, 0, 1234, 2'b00, 77, 2'b00);
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        check("post_rst_valid_a", out_valid_a, 0);
        check("post_rst_valid_b", out_valid_b, 0);
        check("post_rst_hi_a", hi_a, 0);
        check("post_rst_lo_a", lo_a, 0);
        check("post_rst_sticky_a", sticky_a, 0);
        check("post_rst_lo_b", lo_b, 0);
        check("post_rst_sticky_b", sticky_b, 0);
        sv(7, 0, 7, 2'b00, 0, 2'b00);
        idle();
        #1 check("post_rst_lat_s1", out_valid_a, 0);
        @(negedge clk);
        #1;
        check("post_rst_lat_out", out_valid_a, 1);
        check("post_rst_lat_data", out_data_a, 7);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
